// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per architectural register and
// gates decode issue on read-after-write hazards and pending-counter saturation.
module reg_scoreboard #(
    parameter int unsigned REG_COUNT    = 16,
    parameter int unsigned REG_PTR_SIZE = 4,
    parameter int unsigned CNT_WIDTH    = 2,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    D_valid,
    input  logic                    D_uses_src_0,
    input  logic                    D_uses_src_1,
    input  logic [REG_PTR_SIZE-1:0] D_src_0,
    input  logic [REG_PTR_SIZE-1:0] D_src_1,
    input  logic                    D_writes_dst,
    input  logic [REG_PTR_SIZE-1:0] D_dst,
    input  logic                    X_ready,
    input  logic                    W_valid,
    input  logic [REG_PTR_SIZE-1:0] W_dst,
    output logic                    D_issue,
    output logic                    D_stall,
    output logic                    idle,
    output logic                    err_underflow,
    output logic [STAT_WIDTH-1:0]   stall_cycles
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [REG_COUNT-1:0][CNT_WIDTH-1:0] pending_q, pending_d;
    logic                                err_underflow_q, err_underflow_d;
    logic [STAT_WIDTH-1:0]               stall_cycles_q, stall_cycles_d;

    logic                 raw0, raw1, full;
    logic                 inc_en, dec_en, underflow;
    logic [REG_COUNT-1:0] inc_vec, dec_vec;

    // Hazard detection and issue decision; purely combinational on registered counts.
    always_comb begin
        raw0      = D_uses_src_0 & (pending_q[D_src_0] != '0);
        raw1      = D_uses_src_1 & (pending_q[D_src_1] != '0);
        full      = D_writes_dst & (pending_q[D_dst] == CntMax);
        D_issue   = ~reset & D_valid & X_ready & ~raw0 & ~raw1 & ~full & ~flush;
        D_stall   = ~reset & D_valid & ~D_issue;
        idle      = (pending_q == '0);
        inc_en    = D_issue & D_writes_dst;
        // A writeback to an idle register is an error, never a decrement.
        dec_en    = W_valid & (pending_q[W_dst] != '0);
        underflow = W_valid & (pending_q[W_dst] == '0);
    end

    // Next-state for pending counters, sticky underflow flag and stall statistic.
    always_comb begin
        inc_vec         = '0;
        dec_vec         = '0;
        pending_d       = pending_q;
        err_underflow_d = err_underflow_q | underflow;
        stall_cycles_d  = stall_cycles_q;

        if (inc_en) inc_vec[D_dst] = 1'b1;
        if (dec_en) dec_vec[W_dst] = 1'b1;

        if (flush) begin
            pending_d = '0;
        end else begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                case ({inc_vec[i], dec_vec[i]})
                    2'b10:   pending_d[i] = pending_q[i] + CNT_WIDTH'(1);
                    2'b01:   pending_d[i] = pending_q[i] - CNT_WIDTH'(1);
                    default: pending_d[i] = pending_q[i];
                endcase
            end
        end

        // Saturate rather than wrap so long stalls stay visible.
        if (D_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + STAT_WIDTH'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q       <= '0;
            err_underflow_q <= 1'b0;
            stall_cycles_q  <= '0;
        end else begin
            pending_q       <= pending_d;
            err_underflow_q <= err_underflow_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign err_underflow = err_underflow_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed table, hand sequences,
// saturation run and randomized traffic against a per-register count model.
module tb_reg_scoreboard;

    typedef struct {
        bit       rst, fl, v, u0, u1;
        bit [3:0] s0, s1;
        bit       wd;
        bit [3:0] d;
        bit       xr, wv;
        bit [3:0] wdst;
    } stim_t;

    typedef struct {
        stim_t s;
        bit    e_issue, e_stall, e_idle, e_err;
        int    e_sc;
    } row_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0, flush = 1'b0, D_valid = 1'b0;
    logic        D_uses_src_0 = 1'b0, D_uses_src_1 = 1'b0, D_writes_dst = 1'b0;
    logic [3:0]  D_src_0 = '0, D_src_1 = '0, D_dst = '0, W_dst = '0;
    logic        X_ready = 1'b0, W_valid = 1'b0;
    logic        D_issue, D_stall, idle, err_underflow;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .D_valid      (D_valid),
        .D_uses_src_0 (D_uses_src_0),
        .D_uses_src_1 (D_uses_src_1),
        .D_src_0      (D_src_0),
        .D_src_1      (D_src_1),
        .D_writes_dst (D_writes_dst),
        .D_dst        (D_dst),
        .X_ready      (X_ready),
        .W_valid      (W_valid),
        .W_dst        (W_dst),
        .D_issue      (D_issue),
        .D_stall      (D_stall),
        .idle         (idle),
        .err_underflow(err_underflow),
        .stall_cycles (stall_cycles)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: outstanding write count per register, sticky error, stall count.
    int pend[16];
    bit m_err;
    int m_sc;
    bit model_ok = 1'b0;

    function automatic stim_t mk(bit rst, bit fl, bit v, bit u0, bit u1, bit [3:0] s0,
                                 bit [3:0] s1, bit wd, bit [3:0] d, bit xr, bit wv,
                                 bit [3:0] wdst);
        stim_t s;
        s.rst = rst; s.fl = fl; s.v = v; s.u0 = u0; s.u1 = u1; s.s0 = s0; s.s1 = s1;
        s.wd = wd; s.d = d; s.xr = xr; s.wv = wv; s.wdst = wdst;
        return s;
    endfunction

    function automatic bit m_issue(stim_t s);
        if (s.rst || s.fl || !s.v || !s.xr) return 1'b0;
        if (s.u0 && pend[s.s0] > 0) return 1'b0;
        if (s.u1 && pend[s.s1] > 0) return 1'b0;
        if (s.wd && pend[s.d] >= 3) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(stim_t s);
        int  pre[16];
        bit  iss, st;
        if (s.rst) begin
            foreach (pend[i]) pend[i] = 0;
            m_err    = 1'b0;
            m_sc     = 0;
            model_ok = 1'b1;
            return;
        end
        pre = pend;
        iss = m_issue(s);
        st  = s.v && !iss;
        if (s.fl) begin
            foreach (pend[i]) pend[i] = 0;
        end else begin
            if (iss && s.wd) pend[s.d] = pend[s.d] + 1;
            if (s.wv && pre[s.wdst] > 0) pend[s.wdst] = pend[s.wdst] - 1;
        end
        if (s.wv && pre[s.wdst] == 0) m_err = 1'b1;
        if (st && m_sc < 65535) m_sc = m_sc + 1;
    endtask

    // One clock: drive at negedge, sample 4 units later, compare with model, then advance.
    task automatic step(input stim_t s, input string tag, output bit o_is, output bit o_st,
                        output bit o_id, output bit o_er, output int o_sc);
        bit m_idle;
        bit iss;
        @(negedge clk);
        reset = s.rst; flush = s.fl; D_valid = s.v; D_uses_src_0 = s.u0;
        D_uses_src_1 = s.u1; D_src_0 = s.s0; D_src_1 = s.s1; D_writes_dst = s.wd;
        D_dst = s.d; X_ready = s.xr; W_valid = s.wv; W_dst = s.wdst;
        #4;
        o_is = D_issue; o_st = D_stall; o_id = idle; o_er = err_underflow;
        o_sc = int'(stall_cycles);
        if (model_ok) begin
            m_idle = 1'b1;
            foreach (pend[i]) if (pend[i] != 0) m_idle = 1'b0;
            iss = m_issue(s);
            chk({tag, ".issue"}, 32'(D_issue), 32'(iss));
            chk({tag, ".stall"}, 32'(D_stall), 32'(!s.rst && s.v && !iss));
            chk({tag, ".idle"}, 32'(idle), 32'(m_idle));
            chk({tag, ".err"}, 32'(err_underflow), 32'(m_err));
            chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_sc));
        end
        @(posedge clk);
        model_update(s);
    endtask

    row_t  tbl[16];
    stim_t z;
    bit    is, st, id, er;
    int    sc;

    initial begin
        z = mk(0,0,0,0,0,0,0,0,0,0,0,0);
        //            rst fl v u0 u1 s0 s1 wd d xr wv wdst
        tbl[0]  = '{mk(1,0,1,0,0,0,0,0,0,1,0,0), 0,0,1,0,0};
        tbl[1]  = '{mk(0,0,1,1,0,3,0,0,0,1,0,0), 1,0,1,0,0};
        tbl[2]  = '{mk(0,0,1,0,0,0,0,1,5,1,0,0), 1,0,1,0,0};
        tbl[3]  = '{mk(0,0,1,1,0,5,0,0,0,1,0,0), 0,1,0,0,0};
        tbl[4]  = '{mk(0,0,1,0,1,0,5,0,0,1,0,0), 0,1,0,0,1};
        tbl[5]  = '{mk(0,0,1,1,0,5,0,0,0,1,1,5), 0,1,0,0,2};
        tbl[6]  = '{mk(0,0,1,1,0,5,0,0,0,1,0,0), 1,0,1,0,3};
        tbl[7]  = '{mk(0,0,1,0,0,0,0,1,2,1,0,0), 1,0,1,0,3};
        tbl[8]  = '{mk(0,0,1,0,0,0,0,1,2,1,1,2), 1,0,0,0,3};
        tbl[9]  = '{mk(0,0,0,0,0,0,0,0,0,0,1,2), 0,0,0,0,3};
        tbl[10] = '{mk(0,0,1,0,0,0,0,0,0,0,0,0), 0,1,1,0,3};
        tbl[11] = '{mk(0,0,0,0,0,0,0,0,0,0,1,9), 0,0,1,0,4};
        tbl[12] = '{mk(0,1,0,0,0,0,0,0,0,0,0,0), 0,0,1,1,4};
        tbl[13] = '{z,                           0,0,1,1,4};
        tbl[14] = '{mk(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,1,1,4};
        tbl[15] = '{z,                           0,0,1,0,0};

        step(mk(1,0,0,0,0,0,0,0,0,0,0,0), "init", is, st, id, er, sc);

        // Directed table
        for (int r = 0; r < 16; r++) begin
            step(tbl[r].s, $sformatf("tbl%0d", r), is, st, id, er, sc);
            chk($sformatf("tbl%0d.exp_issue", r), 32'(is), 32'(tbl[r].e_issue));
            chk($sformatf("tbl%0d.exp_stall", r), 32'(st), 32'(tbl[r].e_stall));
            chk($sformatf("tbl%0d.exp_idle", r), 32'(id), 32'(tbl[r].e_idle));
            chk($sformatf("tbl%0d.exp_err", r), 32'(er), 32'(tbl[r].e_err));
            chk($sformatf("tbl%0d.exp_sc", r), 32'(sc), 32'(tbl[r].e_sc));
        end

        // Saturation of the pending counter for R7
        for (int k = 0; k < 3; k++) begin
            step(mk(0,0,1,0,0,0,0,1,7,1,0,0), "r7fill", is, st, id, er, sc);
            chk($sformatf("r7fill%0d.issue", k), 32'(is), 32'd1);
        end
        step(mk(0,0,1,0,0,0,0,1,7,1,0,0), "r7full", is, st, id, er, sc);
        chk("r7full.stall", 32'(st), 32'd1);
        step(mk(0,0,1,0,0,0,0,1,7,1,1,7), "r7wb", is, st, id, er, sc);
        chk("r7wb.stall_nobypass", 32'(st), 32'd1);
        step(mk(0,0,1,0,0,0,0,1,7,1,0,0), "r7after", is, st, id, er, sc);
        chk("r7after.issue", 32'(is), 32'd1);

        // Flush with pending R1=2, R4=1 and an issuing candidate to R6
        step(mk(0,1,0,0,0,0,0,0,0,0,0,0), "preflush", is, st, id, er, sc);
        step(mk(0,0,1,0,0,0,0,1,1,1,0,0), "r1a", is, st, id, er, sc);
        step(mk(0,0,1,0,0,0,0,1,1,1,0,0), "r1b", is, st, id, er, sc);
        step(mk(0,0,1,0,0,0,0,1,4,1,0,0), "r4", is, st, id, er, sc);
        step(mk(0,1,1,0,0,0,0,1,6,1,0,0), "flush", is, st, id, er, sc);
        chk("flush.issue", 32'(is), 32'd0);
        step(mk(0,0,1,1,1,6,1,0,0,1,0,0), "postflush", is, st, id, er, sc);
        chk("postflush.idle", 32'(id), 32'd1);
        chk("postflush.r6_r1_clear", 32'(is), 32'd1);

        // Self-dependence: src==dst with nothing pending issues
        step(mk(0,0,1,1,0,8,0,1,8,1,0,0), "selfdep", is, st, id, er, sc);
        chk("selfdep.issue", 32'(is), 32'd1);
        step(mk(0,0,1,1,0,8,0,0,0,1,0,0), "selfdep2", is, st, id, er, sc);
        chk("selfdep2.stall", 32'(st), 32'd1);

        // Stall statistic saturation
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0), "satrst", is, st, id, er, sc);
        step(mk(0,0,1,0,0,0,0,1,0,1,0,0), "satseed", is, st, id, er, sc);
        for (int k = 0; k < 65540; k++) begin
            step(mk(0,0,1,1,0,0,0,0,0,1,0,0), "sat", is, st, id, er, sc);
        end
        step(mk(0,0,1,1,0,0,0,0,0,1,0,0), "satend", is, st, id, er, sc);
        chk("sat.stall_cycles", 32'(sc), 32'h0000_ffff);
        step(mk(1,0,0,0,0,0,0,0,0,0,0,0), "satclr", is, st, id, er, sc);

        // Randomized traffic on a narrow register window to provoke hazards
        for (int k = 0; k < 1000; k++) begin
            stim_t s;
            s.rst  = ($urandom_range(0, 99) == 0);
            s.fl   = ($urandom_range(0, 39) == 0);
            s.v    = ($urandom_range(0, 3) != 0);
            s.u0   = ($urandom_range(0, 1) != 0);
            s.u1   = ($urandom_range(0, 1) != 0);
            s.s0   = 4'($urandom_range(0, 5));
            s.s1   = 4'($urandom_range(0, 5));
            s.wd   = ($urandom_range(0, 3) != 0);
            s.d    = 4'($urandom_range(0, 5));
            s.xr   = ($urandom_range(0, 4) != 0);
            s.wv   = !s.fl && ($urandom_range(0, 2) == 0);
            s.wdst = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 5));
            step(s, $sformatf("rnd%0d", k), is, st, id, er, sc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
